song_player: RTL and testbench
==============================

# song_player

Upstream note source for the lantern display. It steps through a fixed 14-note melody ROM and drives a square-wave buzzer output at each note's pitch. It also presents the current note number (1-7, 0 = silent) on `spec_flag`, which feeds the 7-LED lantern stage directly. Playback can be paused, resumed and restarted, and the melody loops indefinitely.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz; used to derive tone half-periods.
- `BEAT_CYC`, 12_500_000: clock cycles per beat (250 ms).
- `GAP_CYC`, 1_250_000: silent articulation cycles at the end of every note; must be < `BEAT_CYC`.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `play_en` in 1: level; 1 = play/advance, 0 = pause.
- `restart` in 1: single-cycle synchronous pulse; rewinds the song to entry 0.
- `beep` out 1: buzzer square wave.
- `spec_flag` out 3: current sounding note, 0 when silent. Goes to the lantern stage.
- `note_idx` out 4: current ROM index, 0..13.
- `song_done` out 1: one-cycle pulse when the last entry completes.

## Operation
- ROM entry = {note[2:0], beats[1:0]}; duration = (beats+1)*`BEAT_CYC`.
- Melody by index 0..13 (note/beats+1): 1/1 1/1 5/1 5/1 6/1 6/1 5/2 4/1 4/1 3/1 3/1 2/1 2/1 1/2. Total 16 beats.
- Half-period HALF(n) = `CLK_FREQ`/(2*f), truncated. Frequencies: f(1..7) = 262, 294, 330, 349, 392, 440, 494 Hz. At 50 MHz the half-periods are 95419, 85034, 75757, 71633, 63775, 56818, 50607. `tone_cnt` is ≥17 bits.
- FSM states: IDLE, TONE, GAP.
  - IDLE → TONE: `play_en`=1. Loads entry `note_idx`, `note_cnt`=0.
  - TONE → GAP: `note_cnt` reaches `dur`-`GAP_CYC`.
  - GAP → TONE: `note_cnt` = `dur`-1. Advances to the next entry.
- Entry advance: `note_idx`+1. From index 13, wraps to 0 and pulses `song_done` on that edge. Playback continues without passing through IDLE.
- Tone generator, in TONE with note≠0: `tone_cnt` counts 0..HALF-1. At HALF-1, `beep` toggles and `tone_cnt`=0.
  - On every entry into TONE, `tone_cnt`=0 and `beep`=0.
  - In GAP and IDLE, `beep`=0.
- `spec_flag` = note of the current entry while in TONE; 0 in GAP and IDLE.
- Pause (`play_en`=0 while in TONE/GAP):
  - State, `note_idx`, `note_cnt`, `tone_cnt` and `beep` phase are all frozen.
  - Outputs `beep` and `spec_flag` are forced to 0.
  - When `play_en` returns to 1, counting continues from the frozen cycle. `beep` resumes from the frozen phase.
- `restart`=1 (takes priority over `play_en`):
  - `note_idx`=0, `note_cnt`=0, `tone_cnt`=0, `beep`=0, `spec_flag`=0, `song_done`=0.
  - Next state is TONE if `play_en`=1, else IDLE.
- Reset (any time, including mid-note): state IDLE, `note_idx`=0, all counters 0.
- Reset values of outputs: `beep`=0, `spec_flag`=0, `note_idx`=0, `song_done`=0.

## Timing
- All outputs are registered and update on the same edge as the state/counter change that causes them.
- `play_en` rises while in IDLE:
  - The next edge enters TONE.
  - `spec_flag`=note(0) from that edge onward.
- `play_en` falls: the next edge forces `beep`/`spec_flag` to 0. Latency is 1 cycle in both directions.
- A note occupies exactly `dur` active cycles (cycles with `play_en`=1):
  - First `dur`-`GAP_CYC` cycles: `spec_flag`=note.
  - Last `GAP_CYC` cycles: `spec_flag`=0.
- `song_done` is high for exactly 1 cycle, coincident with `note_idx` returning to 0.
- A pulse on `restart` while `play_en`=1 gives `spec_flag`=note(0)=1 on the edge after the pulse. During the pulse edge itself, the outputs are 0.

## Test plan
Parameters for all tests: `CLK_FREQ`=10_000, `BEAT_CYC`=100, `GAP_CYC`=10. This gives HALF(1)=19, HALF(5)=12, HALF(6)=11.
- Reset, then `play_en`=0 for 500 cycles → all outputs 0, `note_idx`=0 throughout.
- Raise `play_en` → from the next edge:
  - `spec_flag`=1 for 90 cycles, and `beep` toggles every 19 cycles starting low.
  - Then 10 cycles of `spec_flag`=0 and `beep`=0.
  - Then `note_idx`=1 with `spec_flag`=1 again.
- Continuous play:
  - Index 6 gives `spec_flag`=5 for 190 cycles, then a 10-cycle gap.
  - At 1600 cycles after start, `song_done` pulses once and `note_idx`=0. The second pass matches the first.
- Drop `play_en` 50 cycles into index 0 for 30 cycles:
  - `spec_flag`/`beep` are 0 one cycle later, and `note_idx` is held.
  - On resume, `spec_flag`=1 for 40 more active cycles before the gap. The `beep` phase continues unbroken.
- `restart` pulse at index 9 with `play_en`=1 → `note_idx`=0 and the next edge shows `spec_flag`=1. No `song_done` is generated.
- Assert `rst_n`=0 asynchronously mid-tone at index 4 → outputs 0 immediately, without waiting for a clock edge. After release with `play_en`=1, playback starts at index 0.

Source files
------------

// File: rtl/song_player.sv
// rtl/song_player.sv - 14-note melody player driving a square-wave buzzer and lantern note code
//
// Steps through a fixed melody ROM and toggles beep at the pitch of each
// note. Each note sounds for its duration minus a short silent gap at the
// end. Playback can be paused with play_en, rewound with restart, and loops
// indefinitely.
//
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   play_en    level: 1 = play/advance, 0 = pause (state frozen, outputs silent)
//   restart    single-cycle pulse: rewind to entry 0 (priority over play_en)
//   beep       buzzer square wave
//   spec_flag  note (1..7) currently sounding, 0 when silent
//   note_idx   current ROM index 0..13
//   song_done  one-cycle pulse when entry 13 completes and playback wraps to 0
module song_player #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BEAT_CYC = 12_500_000,
    parameter int GAP_CYC  = 1_250_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       play_en,
    input  logic       restart,
    output logic       beep,
    output logic [2:0] spec_flag,
    output logic [3:0] note_idx,
    output logic       song_done
);

    // The lowest note has the longest half-period; never narrower than 17 bits.
    localparam int HALF_MAX = CLK_FREQ / (2 * 262);
    localparam int TW_CALC  = $clog2(HALF_MAX + 1);
    localparam int TW       = (TW_CALC > 17) ? TW_CALC : 17;
    localparam int NW       = $clog2(4 * BEAT_CYC + 1);
    localparam logic [3:0] LAST_IDX = 4'd13;

    typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

    // Entry = {note[2:0], beats[1:0]}; duration is (beats+1) beats.
    function automatic logic [4:0] rom(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1:   rom = {3'd1, 2'd0};
            4'd2, 4'd3:   rom = {3'd5, 2'd0};
            4'd4, 4'd5:   rom = {3'd6, 2'd0};
            4'd6:         rom = {3'd5, 2'd1};
            4'd7, 4'd8:   rom = {3'd4, 2'd0};
            4'd9, 4'd10:  rom = {3'd3, 2'd0};
            4'd11, 4'd12: rom = {3'd2, 2'd0};
            4'd13:        rom = {3'd1, 2'd1};
            default:      rom = 5'd0;
        endcase
    endfunction

    function automatic logic [TW-1:0] half_of(input logic [2:0] note);
        case (note)
            3'd1:    half_of = TW'(CLK_FREQ / (2 * 262));
            3'd2:    half_of = TW'(CLK_FREQ / (2 * 294));
            3'd3:    half_of = TW'(CLK_FREQ / (2 * 330));
            3'd4:    half_of = TW'(CLK_FREQ / (2 * 349));
            3'd5:    half_of = TW'(CLK_FREQ / (2 * 392));
            3'd6:    half_of = TW'(CLK_FREQ / (2 * 440));
            3'd7:    half_of = TW'(CLK_FREQ / (2 * 494));
            default: half_of = TW'(1);
        endcase
    endfunction

    state_t        state_q, state_d;
    logic [3:0]    idx_d;
    logic [NW-1:0] note_cnt, cnt_d;
    logic [TW-1:0] tone_cnt, tone_d;
    logic          phase, phase_d;   // beep phase, kept while outputs are muted
    logic          hold, hold_d;     // first play edge after a restart shows note 0 without counting
    logic          beep_d, done_d;
    logic [2:0]    spec_d;

    logic [4:0]    cur_entry;
    logic [2:0]    cur_note;
    logic [3:0]    nxt_idx;
    logic [2:0]    nxt_note;
    logic [TW-1:0] half_m1;
    logic [NW-1:0] tone_end, gap_end;
    logic [4:0]    nxt_entry;

    always_comb begin
        cur_entry = rom(note_idx);
        cur_note  = cur_entry[4:2];
        nxt_idx   = (note_idx == LAST_IDX) ? 4'd0 : note_idx + 4'd1;
        nxt_entry = rom(nxt_idx);
        nxt_note  = nxt_entry[4:2];
        half_m1   = half_of(cur_note) - TW'(1);
        // Last counted cycle of the sounding part, and last cycle of the note.
        tone_end  = NW'((int'(cur_entry[1:0]) + 1) * BEAT_CYC - GAP_CYC - 1);
        gap_end   = NW'((int'(cur_entry[1:0]) + 1) * BEAT_CYC - 1);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = note_idx;
        cnt_d   = note_cnt;
        tone_d  = tone_cnt;
        phase_d = phase;
        hold_d  = hold;
        beep_d  = 1'b0;
        spec_d  = 3'd0;
        done_d  = 1'b0;

        if (restart) begin
            idx_d   = 4'd0;
            cnt_d   = '0;
            tone_d  = '0;
            phase_d = 1'b0;
            hold_d  = play_en;
            state_d = play_en ? TONE : IDLE;
        end else if (play_en) begin
            case (state_q)
                IDLE: begin
                    state_d = TONE;
                    cnt_d   = '0;
                    tone_d  = '0;
                    phase_d = 1'b0;
                    hold_d  = 1'b0;
                    spec_d  = cur_note;
                end
                TONE: begin
                    if (hold) begin
                        hold_d = 1'b0;
                        spec_d = cur_note;
                        beep_d = phase;
                    end else if (note_cnt == tone_end) begin
                        state_d = GAP;
                        cnt_d   = note_cnt + NW'(1);
                        tone_d  = '0;
                        phase_d = 1'b0;
                    end else begin
                        cnt_d  = note_cnt + NW'(1);
                        spec_d = cur_note;
                        if (cur_note != 3'd0) begin
                            if (tone_cnt == half_m1) begin
                                tone_d  = '0;
                                phase_d = ~phase;
                            end else begin
                                tone_d = tone_cnt + TW'(1);
                            end
                        end
                        beep_d = phase_d;
                    end
                end
                GAP: begin
                    if (note_cnt == gap_end) begin
                        state_d = TONE;
                        cnt_d   = '0;
                        tone_d  = '0;
                        phase_d = 1'b0;
                        idx_d   = nxt_idx;
                        done_d  = (note_idx == LAST_IDX);
                        spec_d  = nxt_note;
                    end else begin
                        cnt_d = note_cnt + NW'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            note_idx  <= 4'd0;
            note_cnt  <= '0;
            tone_cnt  <= '0;
            phase     <= 1'b0;
            hold      <= 1'b0;
            beep      <= 1'b0;
            spec_flag <= 3'd0;
            song_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            note_idx  <= idx_d;
            note_cnt  <= cnt_d;
            tone_cnt  <= tone_d;
            phase     <= phase_d;
            hold      <= hold_d;
            beep      <= beep_d;
            spec_flag <= spec_d;
            song_done <= done_d;
        end
    end

endmodule

// File: tb/tb_song_player.sv
// tb/tb_song_player.sv - self-checking bench for song_player against an active-cycle position model
module tb_song_player;

    localparam int CLK_FREQ = 10_000;
    localparam int BEAT_CYC = 100;
    localparam int GAP_CYC  = 10;
    localparam int SONG     = 16 * BEAT_CYC;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       play_en = 1'b0;
    logic       restart = 1'b0;
    logic       beep;
    logic [2:0] spec_flag;
    logic [3:0] note_idx;
    logic       song_done;

    song_player #(
        .CLK_FREQ (CLK_FREQ),
        .BEAT_CYC (BEAT_CYC),
        .GAP_CYC  (GAP_CYC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .play_en   (play_en),
        .restart   (restart),
        .beep      (beep),
        .spec_flag (spec_flag),
        .note_idx  (note_idx),
        .song_done (song_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int done_seen = 0;

    int melody_note  [14] = '{1, 1, 5, 5, 6, 6, 5, 4, 4, 3, 3, 2, 2, 1};
    int melody_beats [14] = '{1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 2};
    int freq         [8]  = '{0, 262, 294, 330, 349, 392, 440, 494};

    // Model: position (in active cycles) within the 1600-cycle song.
    bit m_started = 0;
    bit m_hold    = 0;
    int m_pos     = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Expected index, note and beep level for a song position.
    task automatic expect_at(input int p, output int e_idx, output int e_note, output int e_beep);
        int acc = 0;
        int o;
        int dur;
        int half;
        e_idx = 0; e_note = 0; e_beep = 0;
        for (int i = 0; i < 14; i++) begin
            dur = melody_beats[i] * BEAT_CYC;
            if (p < acc + dur) begin
                o = p - acc;
                e_idx = i;
                if (o < dur - GAP_CYC) begin
                    half = CLK_FREQ / (2 * freq[melody_note[i]]);
                    e_note = melody_note[i];
                    e_beep = (o / half) % 2;
                end
                break;
            end
            acc += dur;
        end
    endtask

    task automatic step(input logic pe, input logic rs);
        int ei, en, eb;
        bit show;
        bit exp_done;
        play_en = pe;
        restart = rs;
        @(posedge clk);
        #1;
        show = 0;
        exp_done = 0;
        if (rs) begin
            m_pos = 0;
            m_started = pe;
            m_hold = pe;
        end else if (pe) begin
            if (!m_started) begin
                m_started = 1;
                m_pos = 0;
                m_hold = 0;
            end else if (m_hold) begin
                m_hold = 0;
            end else begin
                m_pos++;
                if (m_pos == SONG) begin
                    m_pos = 0;
                    exp_done = 1;
                end
            end
            show = 1;
        end
        expect_at(m_pos, ei, en, eb);
        if (song_done === 1'b1) done_seen++;
        chk("note_idx", 32'(note_idx), 32'(ei));
        chk("spec_flag", 32'(spec_flag), show ? 32'(en) : 32'd0);
        chk("beep", 32'(beep), show ? 32'(eb) : 32'd0);
        chk("song_done", 32'(song_done), 32'(exp_done));
    endtask

    task automatic run_to(input int target);
        int guard = 0;
        while (m_pos != target && guard < 5000) begin
            step(1'b1, 1'b0);
            guard++;
        end
        chk("run_to_bound", 32'(guard < 5000), 32'd1);
    endtask

    initial begin
        // Reset held across edges: everything must be quiet.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_beep", 32'(beep), 32'd0);
        chk("rst_spec", 32'(spec_flag), 32'd0);
        chk("rst_idx", 32'(note_idx), 32'd0);
        chk("rst_done", 32'(song_done), 32'd0);
        rst_n = 1'b1;

        // Idle with play_en low.
        repeat (500) step(1'b0, 1'b0);

        // First full pass plus the wrap edge.
        repeat (SONG + 1) step(1'b1, 1'b0);
        chk("done_count_pass1", 32'(done_seen), 32'd1);
        chk("idx_after_wrap", 32'(note_idx), 32'd0);

        // Pause 50 cycles into index 0 for 30 cycles, then resume.
        repeat (49) step(1'b1, 1'b0);
        repeat (30) step(1'b0, 1'b0);
        chk("pause_idx_held", 32'(note_idx), 32'd0);
        repeat (40) step(1'b1, 1'b0);
        chk("resume_spec_last", 32'(spec_flag), 32'd1);
        step(1'b1, 1'b0);
        chk("resume_gap", 32'(spec_flag), 32'd0);

        // Restart at index 9 while playing.
        run_to(1030);
        chk("pre_restart_idx", 32'(note_idx), 32'd9);
        done_seen = 0;
        step(1'b1, 1'b1);
        chk("restart_spec0", 32'(spec_flag), 32'd0);
        step(1'b1, 1'b0);
        chk("after_restart_spec", 32'(spec_flag), 32'd1);
        chk("restart_no_done", 32'(done_seen), 32'd0);

        // Randomized pauses and occasional restarts.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
        end

        // Restart while paused goes back to idle; then play resumes from entry 0.
        step(1'b0, 1'b1);
        repeat (5) step(1'b0, 1'b0);
        run_to(420);
        chk("pre_reset_spec", 32'(spec_flag), 32'd6);

        // Asynchronous reset mid-tone at index 4.
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_beep", 32'(beep), 32'd0);
        chk("async_spec", 32'(spec_flag), 32'd0);
        chk("async_idx", 32'(note_idx), 32'd0);
        m_started = 0;
        m_hold = 0;
        m_pos = 0;
        play_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("async_hold_spec", 32'(spec_flag), 32'd0);
        rst_n = 1'b1;
        repeat (250) step(1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
